// File: rtl/qspi_rom_fetch_pkg.sv
// Shared constants for the QSPI cartridge ROM fetcher: FSM encoding and
// quad fast-read protocol framing.
package qspi_rom_fetch_pkg;

  localparam logic [3:0] S_BOOT  = 4'd0;
  localparam logic [3:0] S_CRM   = 4'd1;
  localparam logic [3:0] S_GAP   = 4'd2;
  localparam logic [3:0] S_IDLE  = 4'd3;
  localparam logic [3:0] S_CMD   = 4'd4;
  localparam logic [3:0] S_ADDR  = 4'd5;
  localparam logic [3:0] S_MODE  = 4'd6;
  localparam logic [3:0] S_DUMMY = 4'd7;
  localparam logic [3:0] S_DATA  = 4'd8;

  localparam logic [7:0] QSPI_CMD_QREAD = 8'hEB;
  localparam logic [7:0] QSPI_MODE_CONT = 8'hA0;

  localparam int CRM_SCK  = 8;
  localparam int CMD_SCK  = 8;
  localparam int ADDR_SCK = 6;
  localparam int MODE_SCK = 2;
  localparam int DATA_SCK = 2;

  // Shifter counts periods down to zero, so it is loaded with n-1.
  function automatic logic [3:0] sck_cnt(int n);
    return 4'(n - 1);
  endfunction

endpackage

// File: rtl/qspi_shifter.sv
// SCK phase generator and nibble/bit shift register for one QSPI segment.
// Loaded by the FSM; raises done in the last high phase so a reload is seamless.
module qspi_shifter
  import qspi_rom_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld,
  input  logic        ld_quad,
  input  logic [3:0]  ld_oe,
  input  logic [3:0]  ld_cnt,
  input  logic [31:0] ld_data,
  input  logic [3:0]  io_in,
  output logic        sck,
  output logic [3:0]  io_out,
  output logic [3:0]  io_oe,
  output logic        done,
  output logic [7:0]  rx_byte
);

  logic        active;
  logic        phase;
  logic        quad;
  logic [3:0]  cnt;
  logic [3:0]  oe;
  logic [31:0] shreg;

  assign sck     = phase;
  assign done    = active & phase & (cnt == 4'd0);
  assign io_out  = quad ? shreg[31:28] : {3'b000, shreg[31]};
  assign io_oe   = oe;
  // Includes the nibble being captured on this edge, for use alongside done.
  assign rx_byte = {shreg[3:0], io_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      phase  <= 1'b0;
      quad   <= 1'b0;
      cnt    <= 4'd0;
      oe     <= 4'h0;
      shreg  <= 32'h0;
    end else if (ld) begin
      active <= 1'b1;
      phase  <= 1'b0;
      quad   <= ld_quad;
      cnt    <= ld_cnt;
      oe     <= ld_oe;
      shreg  <= ld_data;
    end else if (active) begin
      phase <= ~phase;
      if (phase) begin
        shreg <= quad ? {shreg[27:0], io_in} : {shreg[30:0], io_in[1]};
        cnt   <= cnt - 4'd1;
        if (cnt == 4'd0) begin
          active <= 1'b0;
          oe     <= 4'h0;
        end
      end
    end
  end

endmodule

// File: rtl/qspi_rom_fetch.sv
// QSPI quad fast-read (0xEB) master returning one cartridge ROM byte per
// request, using continuous-read mode after the first fetch.
module qspi_rom_fetch
  import qspi_rom_fetch_pkg::*;
#(
  parameter logic [23:0] ROM_BASE  = 24'h100000,
  parameter int          DUMMY_SCK = 4,
  parameter int          CS_GAP    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [11:0] req_addr,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        spi_sck,
  output logic        spi_cs_n,
  output logic [3:0]  spi_io_out,
  output logic [3:0]  spi_io_oe,
  input  logic [3:0]  spi_io_in
);

  logic [3:0]  state;
  logic        cont;
  logic [23:0] addr;
  logic [3:0]  gap_cnt;
  logic [23:0] fetch_addr;

  logic        ld;
  logic        ld_quad;
  logic [3:0]  ld_oe;
  logic [3:0]  ld_cnt;
  logic [31:0] ld_data;
  logic        done;
  logic [7:0]  rx_byte;

  assign fetch_addr = ROM_BASE + {12'h000, req_addr};
  assign req_ready  = (state == S_IDLE);

  always_comb begin
    ld      = 1'b0;
    ld_quad = 1'b1;
    ld_oe   = 4'hF;
    ld_cnt  = 4'd0;
    ld_data = 32'h0;
    case (state)
      S_BOOT: begin
        // All-ones mode bits kick the flash out of any stale continuous mode.
        ld      = 1'b1;
        ld_cnt  = sck_cnt(CRM_SCK);
        ld_data = '1;
      end
      S_IDLE: begin
        if (req_valid) begin
          ld = 1'b1;
          if (cont) begin
            ld_cnt  = sck_cnt(ADDR_SCK);
            ld_data = {fetch_addr, 8'h00};
          end else begin
            ld_quad = 1'b0;
            ld_oe   = 4'b0001;
            ld_cnt  = sck_cnt(CMD_SCK);
            ld_data = {QSPI_CMD_QREAD, 24'h0};
          end
        end
      end
      S_CMD: begin
        ld      = done;
        ld_cnt  = sck_cnt(ADDR_SCK);
        ld_data = {addr, 8'h00};
      end
      S_ADDR: begin
        ld      = done;
        ld_cnt  = sck_cnt(MODE_SCK);
        ld_data = {QSPI_MODE_CONT, 24'h0};
      end
      S_MODE: begin
        ld     = done;
        ld_oe  = 4'h0;
        ld_cnt = sck_cnt(DUMMY_SCK);
      end
      S_DUMMY: begin
        ld     = done;
        ld_oe  = 4'h0;
        ld_cnt = sck_cnt(DATA_SCK);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_BOOT;
      cont      <= 1'b0;
      addr      <= 24'h0;
      gap_cnt   <= 4'd0;
      spi_cs_n  <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_BOOT: begin
          spi_cs_n <= 1'b0;
          state    <= S_CRM;
        end
        S_CRM: if (done) begin
          spi_cs_n <= 1'b1;
          gap_cnt  <= 4'(CS_GAP - 1);
          state    <= S_GAP;
        end
        S_GAP: begin
          if (gap_cnt == 4'd0) state <= S_IDLE;
          else                 gap_cnt <= gap_cnt - 4'd1;
        end
        S_IDLE: if (req_valid) begin
          addr     <= fetch_addr;
          spi_cs_n <= 1'b0;
          state    <= cont ? S_ADDR : S_CMD;
        end
        S_CMD:   if (done) state <= S_ADDR;
        S_ADDR:  if (done) state <= S_MODE;
        S_MODE:  if (done) begin
          cont  <= 1'b1;
          state <= S_DUMMY;
        end
        S_DUMMY: if (done) state <= S_DATA;
        S_DATA:  if (done) begin
          rsp_valid <= 1'b1;
          rsp_data  <= rx_byte;
          spi_cs_n  <= 1'b1;
          gap_cnt   <= 4'(CS_GAP - 1);
          state     <= S_GAP;
        end
        default: state <= S_BOOT;
      endcase
    end
  end

  qspi_shifter u_shf (
    .clk     (clk),
    .rst_n   (rst_n),
    .ld      (ld),
    .ld_quad (ld_quad),
    .ld_oe   (ld_oe),
    .ld_cnt  (ld_cnt),
    .ld_data (ld_data),
    .io_in   (spi_io_in),
    .sck     (spi_sck),
    .io_out  (spi_io_out),
    .io_oe   (spi_io_oe),
    .done    (done),
    .rx_byte (rx_byte)
  );

endmodule

// File: tb/tb_qspi_rom_fetch.sv
// Bench for qspi_rom_fetch: a protocol-level flash model decodes the pins and
// serves bytes; fetches are checked for data, latency and pin sequences.
module tb_qspi_rom_fetch;

  localparam logic [23:0] ROM_BASE   = 24'h100000;
  localparam logic [23:0] ROM_BASE_W = 24'hFFFFFF;
  localparam int DUMMY_SCK = 4;
  localparam int CS_GAP    = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic [11:0] req_addr = 12'h0;
  logic        req_ready, rsp_valid, spi_sck, spi_cs_n;
  logic [7:0]  rsp_data;
  logic [3:0]  spi_io_out, spi_io_oe, spi_io_in;

  logic        req_valid_w = 1'b0;
  logic [11:0] req_addr_w = 12'h0;
  logic        req_ready_w, rsp_valid_w, sck_w, cs_n_w;
  logic [7:0]  rsp_data_w;
  logic [3:0]  io_out_w, io_oe_w;
  logic [3:0]  io_in_w = 4'h0;

  qspi_rom_fetch #(.ROM_BASE(ROM_BASE), .DUMMY_SCK(DUMMY_SCK), .CS_GAP(CS_GAP)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_io_out(spi_io_out),
    .spi_io_oe(spi_io_oe), .spi_io_in(spi_io_in)
  );

  qspi_rom_fetch #(.ROM_BASE(ROM_BASE_W), .DUMMY_SCK(DUMMY_SCK), .CS_GAP(CS_GAP)) dut_w (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_w), .req_addr(req_addr_w),
    .req_ready(req_ready_w), .rsp_valid(rsp_valid_w), .rsp_data(rsp_data_w),
    .spi_sck(sck_w), .spi_cs_n(cs_n_w), .spi_io_out(io_out_w),
    .spi_io_oe(io_oe_w), .spi_io_in(io_in_w)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    if (a == 24'h100123) return 8'h5A;
    if (a == 24'h100FFF) return 8'h3C;
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h96;
  endfunction

  // Flash model: decodes command/address/mode by SCK count, drives data nibbles.
  logic [3:0]  fl_io = 4'h0;
  bit          fl_cont = 1'b0;
  bit          fl_ok = 1'b0;
  int          fl_k = 0;
  int          fl_cmdlen = 8;
  logic [7:0]  fl_cmd = 8'h0;
  logic [23:0] fl_addr = 24'h0;
  logic [7:0]  fl_b;
  logic [3:0]  q_io[$];
  logic [3:0]  q_oe[$];
  assign spi_io_in = fl_io;

  always @(negedge spi_cs_n or posedge spi_sck) begin
    if (spi_sck && !spi_cs_n) begin
      fl_k++;
      q_io.push_back(spi_io_out);
      q_oe.push_back(spi_io_oe);
      if (fl_k <= fl_cmdlen) begin
        fl_cmd = {fl_cmd[6:0], spi_io_out[0]};
        if (fl_k == 8) fl_ok = (fl_cmd == 8'hEB);
      end else if (fl_k <= fl_cmdlen + 6) begin
        fl_addr = {fl_addr[19:0], spi_io_out};
      end else if (fl_k == fl_cmdlen + 7) begin
        if (fl_ok) fl_cont = (spi_io_out == 4'hA);
      end
      fl_b = flash_byte(fl_addr);
      if (fl_ok && fl_k == fl_cmdlen + 9 + DUMMY_SCK) fl_io = fl_b[7:4];
      if (fl_ok && fl_k == fl_cmdlen + 10 + DUMMY_SCK) fl_io = fl_b[3:0];
    end else if (!spi_cs_n) begin
      fl_k = 0;
      fl_cmdlen = fl_cont ? 0 : 8;
      fl_ok = fl_cont;
      fl_cmd = 8'h0;
      fl_addr = 24'h0;
      q_io.delete();
      q_oe.delete();
    end
  end

  logic [3:0] q2[$];
  always @(negedge cs_n_w or posedge sck_w) begin
    if (sck_w && !cs_n_w) q2.push_back(io_out_w);
    else if (!cs_n_w) q2.delete();
  end

  int rsp_cnt = 0;
  always @(posedge clk) if (rsp_valid) rsp_cnt++;

  bit ref_cont = 1'b0;

  // Flash-exit sequence after reset release, then the chip-select gap.
  task automatic crm(input string tag);
    int t, low, gap, bad;
    t = 0;
    while (spi_cs_n && t < 20) begin @(negedge clk); t++; end
    low = 0;
    while (!spi_cs_n && low < 64) begin @(negedge clk); low++; end
    chk({tag, "_low"}, low, 16);
    chk({tag, "_nsck"}, q_io.size(), 8);
    bad = 0;
    foreach (q_io[i]) if (q_io[i] !== 4'hF || q_oe[i] !== 4'hF) bad++;
    chk({tag, "_io"}, bad, 0);
    gap = 0;
    bad = 0;
    while (!req_ready && gap < 64) begin
      if (!spi_cs_n || spi_io_oe != 4'h0) bad++;
      @(negedge clk);
      gap++;
    end
    chk({tag, "_gap"}, (gap >= CS_GAP), 1);
    chk({tag, "_gapcs"}, bad, 0);
  endtask

  task automatic fetch(input logic [11:0] a, input string tag);
    int t, n, mism;
    logic [23:0] fa;
    logic [7:0] cmdv;
    logic [3:0] e_io[$];
    logic [3:0] e_oe[$];
    n = (ref_cont ? 0 : 8) + 6 + 2 + DUMMY_SCK + 2;
    fa = ROM_BASE + {12'h000, a};
    cmdv = 8'hEB;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 200) begin @(negedge clk); t++; end
    chk({tag, "_idle"}, req_ready, 1);
    req_valid = 1'b1;
    req_addr = a;
    @(negedge clk);
    req_valid = 1'b0;
    t = 1;
    chk({tag, "_cs"}, spi_cs_n, 0);
    chk({tag, "_rdy0"}, req_ready, 0);
    while (!rsp_valid && t < 200) begin @(negedge clk); t++; end
    chk({tag, "_lat"}, t, 2 * n + 1);
    chk({tag, "_data"}, rsp_data, flash_byte(fa));
    chk({tag, "_csend"}, spi_cs_n, 1);
    if (!ref_cont)
      for (int b = 7; b >= 0; b--) begin e_io.push_back({3'b000, cmdv[b]}); e_oe.push_back(4'h1); end
    for (int k = 5; k >= 0; k--) begin e_io.push_back(fa[k*4 +: 4]); e_oe.push_back(4'hF); end
    e_io.push_back(4'hA); e_oe.push_back(4'hF);
    e_io.push_back(4'h0); e_oe.push_back(4'hF);
    repeat (DUMMY_SCK + 2) begin e_io.push_back(4'h0); e_oe.push_back(4'h0); end
    chk({tag, "_nsck"}, q_io.size(), e_io.size());
    mism = 0;
    for (int i = 0; i < q_io.size() && i < e_io.size(); i++)
      if (q_oe[i] !== e_oe[i] || (e_oe[i] != 4'h0 && q_io[i] !== e_io[i])) mism++;
    chk({tag, "_seq"}, mism, 0);
    while (!req_ready && t < 300) begin @(negedge clk); t++; end
    chk({tag, "_rdylat"}, t, 2 * n + 1 + CS_GAP);
    ref_cont = 1'b1;
  endtask

  initial begin
    int t, base_cnt, nrsp;
    int acc_i[$];
    logic [11:0] acc_a[$];
    logic [11:0] ra;
    logic [23:0] wgot, wexp;

    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 8'h00);
    chk("rst_sck", spi_sck, 0);
    chk("rst_cs_n", spi_cs_n, 1);
    chk("rst_io_out", spi_io_out, 4'h0);
    chk("rst_io_oe", spi_io_oe, 4'h0);
    rst_n = 1'b1;
    crm("crm0");

    // Base offset wrap on the second instance.
    req_valid_w = 1'b1;
    req_addr_w = 12'h002;
    @(negedge clk);
    req_valid_w = 1'b0;
    t = 0;
    while (!rsp_valid_w && t < 200) begin @(negedge clk); t++; end
    chk("wrap_nsck", q2.size(), 22);
    wgot = 24'h0;
    if (q2.size() >= 14) wgot = {q2[8], q2[9], q2[10], q2[11], q2[12], q2[13]};
    wexp = ROM_BASE_W + 24'h000002;
    chk("wrap_addr", wgot, wexp);

    fetch(12'h123, "f1");
    fetch(12'hFFF, "f2");
    for (int r = 0; r < 5; r++) fetch(12'($urandom_range(0, 4095)), "rnd");

    // req_valid held high across two transactions.
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 200) begin @(negedge clk); t++; end
    req_valid = 1'b1;
    req_addr = 12'($urandom_range(0, 4095));
    nrsp = 0;
    for (int i = 0; i < 62; i++) begin
      if (i > 0) @(negedge clk);
      if (rsp_valid) begin
        nrsp++;
        ra = (acc_a.size() > 0) ? acc_a.pop_front() : 12'h0;
        chk("held_data", rsp_data, flash_byte(ROM_BASE + {12'h000, ra}));
      end
      if (req_ready) begin
        acc_i.push_back(i);
        acc_a.push_back(req_addr);
      end else begin
        req_addr = 12'($urandom_range(0, 4095));
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    chk("held_accepts", acc_i.size(), 2);
    chk("held_rsps", nrsp, 2);
    if (acc_i.size() >= 2) chk("held_spacing", acc_i[1] - acc_i[0], 2 * 14 + 1 + CS_GAP);

    // Reset in the middle of a fetch.
    t = 0;
    while (!req_ready && t < 200) begin @(negedge clk); t++; end
    req_valid = 1'b1;
    req_addr = 12'h456;
    @(negedge clk);
    req_valid = 1'b0;
    base_cnt = rsp_cnt;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_cs_n", spi_cs_n, 1);
    chk("mid_sck", spi_sck, 0);
    chk("mid_oe", spi_io_oe, 4'h0);
    chk("mid_ready", req_ready, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ref_cont = 1'b0;
    crm("crm1");
    chk("mid_no_rsp", rsp_cnt, base_cnt);
    fetch(12'($urandom_range(0, 4095)), "post_rst");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule
